// File: rtl/data_mem_access.sv
// Load/store sequencer for the core's data AXI master port: one RV32I access at a time,
// with byte-lane alignment, write-strobe generation, load extension and a pipeline stall.
module data_mem_access #(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               REQ,
    input  logic                               REQ_WE,
    input  logic [2:0]                         REQ_FUNCT3,
    input  logic [31:0]                        REQ_ADDR,
    input  logic [31:0]                        REQ_WDATA,
    output logic                               MEM_WAIT,
    output logic                               DONE,
    output logic                               ERR,
    output logic [31:0]                        RDATA,
    output logic [2:0]                         DBG_STATE,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [3:0]                         M_AXI_WSTRB,
    output logic                               M_AXI_WLAST,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_D  = 3'd2,
        S_WR_AW = 3'd3,
        S_WR_B  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t      state, state_n;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done, w_done;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        req_legal, req_misaligned, req_ok;
    logic        aw_hs, w_hs;
    logic [31:0] lane_word;
    logic [31:0] load_ext;

    // Handshake rule on every channel: a beat transfers on a rising CLK edge where
    // VALID and READY are both high; VALID never drops before that edge.
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    always_comb begin
        req_legal      = REQ_WE ? (REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010})
                                : (REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        req_misaligned = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                         ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
        req_ok         = req_legal && !req_misaligned;
    end

    assign lane_word = M_AXI_RDATA >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = M_AXI_RDATA;
        case (f3_q)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_ext = {24'd0, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_ext = {16'd0, lane_word[15:0]};
            default: load_ext = M_AXI_RDATA;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (REQ) begin
                    we_q    <= REQ_WE;
                    f3_q    <= REQ_FUNCT3;
                    addr_q  <= REQ_ADDR;
                    wdata_q <= REQ_WDATA;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    err_q   <= !req_ok;
                    rdata_q <= 32'd0;
                end
                S_RD_D: if (M_AXI_RVALID) begin
                    rdata_q <= load_ext;
                    err_q   <= (M_AXI_RRESP != 2'b00);
                end
                S_WR_AW: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                S_WR_B: if (M_AXI_BVALID) err_q <= (M_AXI_BRESP != 2'b00);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (REQ) state_n = !req_ok ? S_FIN : (REQ_WE ? S_WR_AW : S_RD_A);
            S_RD_A:  if (M_AXI_ARREADY) state_n = S_RD_D;
            S_RD_D:  if (M_AXI_RVALID) state_n = S_FIN;
            // AW and W may complete in either order or together.
            S_WR_AW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = S_WR_B;
            S_WR_B:  if (M_AXI_BVALID) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        M_AXI_WDATA = wdata_q;
        M_AXI_WSTRB = 4'b1111;
        case (f3_q[1:0])
            2'b00: begin
                M_AXI_WDATA = {4{wdata_q[7:0]}};
                M_AXI_WSTRB = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                M_AXI_WDATA = {2{wdata_q[15:0]}};
                M_AXI_WSTRB = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign M_AXI_ARID    = '0;
    assign M_AXI_AWID    = '0;
    assign M_AXI_ARADDR  = {addr_q[31:2], 2'b00};
    assign M_AXI_AWADDR  = {addr_q[31:2], 2'b00};
    assign M_AXI_ARVALID = (state == S_RD_A);
    assign M_AXI_RREADY  = (state == S_RD_D);
    assign M_AXI_AWVALID = (state == S_WR_AW) && !aw_done;
    assign M_AXI_WVALID  = (state == S_WR_AW) && !w_done;
    assign M_AXI_WLAST   = M_AXI_WVALID;
    assign M_AXI_BREADY  = (state == S_WR_B);

    // FIN drops the stall so the pipeline advances in the same cycle as DONE.
    assign MEM_WAIT  = ((state == S_IDLE) && REQ) || ((state != S_IDLE) && (state != S_FIN));
    assign DONE      = (state == S_FIN);
    assign ERR       = err_q;
    assign RDATA     = rdata_q;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: AXI slave with programmable delays/responses and a
// transaction-level reference model checked every cycle.
module tb_data_mem_access;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ = 1'b0, REQ_WE = 1'b0;
    logic [2:0]  REQ_FUNCT3 = 3'd0;
    logic [31:0] REQ_ADDR = 32'd0, REQ_WDATA = 32'd0;
    logic        MEM_WAIT, DONE, ERR;
    logic [31:0] RDATA;
    logic [2:0]  DBG_STATE;
    logic [0:0]  M_AXI_ARID, M_AXI_AWID;
    logic [31:0] M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA;
    logic        M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0, M_AXI_AWREADY = 1'b0;
    logic        M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic [31:0] M_AXI_RDATA = 32'd0;
    logic [1:0]  M_AXI_RRESP = 2'd0, M_AXI_BRESP = 2'd0;

    data_mem_access dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .MEM_WAIT(MEM_WAIT), .DONE(DONE),
        .ERR(ERR), .RDATA(RDATA), .DBG_STATE(DBG_STATE),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    logic [32:0] exp_q[$];            // {err, rdata} per accepted request
    logic        exp_bad, exp_load;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    bit          zero_wait_chk;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [31:0] r_word;
    logic [1:0]  r_resp, b_resp;

    bit          busy, done_seen;
    bit          ar_hs_f, r_hs_f, aw_hs_f, w_hs_f, b_hs_f;
    bit          ar_wait, aw_wait, w_wait;
    int          n_ar, n_r, n_aw, n_w, n_b, cyc, acc_cyc;
    logic [31:0] last_rdata, cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        last_err;

    function automatic bit is_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        if (f3[1:0] == 2'd1) return a % 2 != 0;
        if (f3[1:0] == 2'd2) return a % 4 != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * lane);
        case (f3)
            3'd0:    return 32'($signed(s[7:0]));
            3'd4:    return 32'(s[7:0]);
            3'd1:    return 32'($signed(s[15:0]));
            3'd5:    return 32'(s[15:0]);
            default: return w;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                busy = 0; ar_hs_f = 0; r_hs_f = 0; aw_hs_f = 0; w_hs_f = 0; b_hs_f = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; last_rdata = 0; last_err = 0;
                continue;
            end
            ar_hs_f = M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs_f  = M_AXI_RVALID && M_AXI_RREADY;
            aw_hs_f = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs_f  = M_AXI_WVALID && M_AXI_WREADY;
            b_hs_f  = M_AXI_BVALID && M_AXI_BREADY;
            if (ar_wait) chk("arvalid_hold", M_AXI_ARVALID, 1);
            if (aw_wait) chk("awvalid_hold", M_AXI_AWVALID, 1);
            if (w_wait)  chk("wvalid_hold", M_AXI_WVALID, 1);
            ar_wait = M_AXI_ARVALID && !M_AXI_ARREADY;
            aw_wait = M_AXI_AWVALID && !M_AXI_AWREADY;
            w_wait  = M_AXI_WVALID && !M_AXI_WREADY;
            chk("wlast", M_AXI_WLAST, M_AXI_WVALID);
            if (M_AXI_ARVALID) begin
                chk("araddr", M_AXI_ARADDR, {exp_addr[31:2], 2'b00});
                chk("arid", M_AXI_ARID, 0);
            end
            if (M_AXI_AWVALID) begin
                chk("awaddr", M_AXI_AWADDR, {exp_addr[31:2], 2'b00});
                chk("awid", M_AXI_AWID, 0);
            end
            if (M_AXI_WVALID) begin
                chk("wdata", M_AXI_WDATA, exp_wdata);
                chk("wstrb", M_AXI_WSTRB, exp_strb);
            end
            if (ar_hs_f) begin n_ar++; cap_araddr = M_AXI_ARADDR; end
            if (r_hs_f)  n_r++;
            if (aw_hs_f) begin n_aw++; cap_awaddr = M_AXI_AWADDR; end
            if (w_hs_f)  begin n_w++; cap_wdata = M_AXI_WDATA; cap_strb = M_AXI_WSTRB; end
            if (b_hs_f)  n_b++;
            chk("mem_wait", MEM_WAIT, busy ? !DONE : REQ);
            if (!busy) begin
                chk("done_idle", DONE, 0);
                chk("rdata_hold", RDATA, last_rdata);
                chk("err_hold", ERR, last_err);
                if (REQ) begin
                    busy = 1; acc_cyc = cyc;
                    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
                end
            end else if (DONE) begin
                logic [32:0] e;
                int lat;
                if (exp_q.size() == 0) begin
                    chk("exp_q_empty", 1, 0);
                    e = '0;
                end else e = exp_q.pop_front();
                chk("done_rdata", RDATA, e[31:0]);
                chk("done_err", ERR, 32'(e[32]));
                chk("n_ar", n_ar, (!exp_bad && exp_load) ? 1 : 0);
                chk("n_r", n_r, (!exp_bad && exp_load) ? 1 : 0);
                chk("n_aw", n_aw, (!exp_bad && !exp_load) ? 1 : 0);
                chk("n_w", n_w, (!exp_bad && !exp_load) ? 1 : 0);
                chk("n_b", n_b, (!exp_bad && !exp_load) ? 1 : 0);
                lat = cyc - acc_cyc;
                if (exp_bad) chk("err_latency", (lat >= 1 && lat <= 2), 1);
                else if (zero_wait_chk) chk("min_latency", lat, 3);
                last_rdata = RDATA; last_err = ERR;
                busy = 0; done_seen = 1;
            end else begin
                chk("rdata_busy", RDATA, 0);
                chk("err_busy", ERR, 0);
            end
        end
    end

    // ---------------- AXI slave ----------------
    int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit  r_pend, b_pend, aw_got, w_got;

    task automatic slave_step();
        if (!RST) begin
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            return;
        end
        if (r_hs_f) begin M_AXI_RVALID = 0; r_pend = 0; M_AXI_RDATA = $urandom; end
        if (ar_hs_f) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; end
        if (r_pend && !M_AXI_RVALID) begin
            if (r_cnt >= r_dly) begin
                M_AXI_RVALID = 1; M_AXI_RDATA = r_word; M_AXI_RRESP = r_resp;
            end else r_cnt++;
        end
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
        if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_cnt++;
        if (aw_hs_f) begin aw_got = 1; aw_cnt = 0; end
        if (w_hs_f)  begin w_got = 1; w_cnt = 0; end
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
        if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
        M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_dly);
        if (M_AXI_WVALID && !M_AXI_WREADY) w_cnt++;
        if (b_hs_f) begin M_AXI_BVALID = 0; b_pend = 0; end
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        if (b_pend && !M_AXI_BVALID) begin
            if (b_cnt >= b_dly) begin M_AXI_BVALID = 1; M_AXI_BRESP = b_resp; end
            else b_cnt++;
        end
    endtask

    initial forever begin
        @(posedge CLK); #1;
        slave_step();
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input bit zw, input int awd);
        zero_wait_chk = zw;
        ar_dly = zw ? 0 : $urandom_range(0, 3);
        r_dly  = zw ? 0 : $urandom_range(0, 3);
        aw_dly = zw ? 0 : $urandom_range(0, 3);
        w_dly  = zw ? 0 : $urandom_range(0, 3);
        b_dly  = zw ? 0 : $urandom_range(0, 3);
        if (awd >= 0) aw_dly = awd;
    endtask

    task automatic launch(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        exp_bad  = is_bad(we, f3, a);
        exp_load = !we;
        exp_addr = a;
        case (f3[1:0])
            2'd0:    begin exp_wdata = {4{wd[7:0]}};  exp_strb = 4'(1 << a[1:0]); end
            2'd1:    begin exp_wdata = {2{wd[15:0]}}; exp_strb = 4'(3 << (2 * a[1])); end
            default: begin exp_wdata = wd;            exp_strb = 4'hF; end
        endcase
        done_seen = 0;
        REQ = 1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = wd;
    endtask

    task automatic apply_reset();
        @(posedge CLK); #3;
        RST = 0;
        REQ = 0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #2 RST = 1;
    endtask

    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rw, input logic [1:0] rr,
                             input logic [1:0] br, input bit zw, input int awd);
        logic [32:0] e;
        set_cfg(zw, awd);
        r_word = rw; r_resp = rr; b_resp = br;
        if (is_bad(we, f3, a))  e = {1'b1, 32'd0};
        else if (!we)           e = {rr != 2'd0, load_val(f3, a[1:0], rw)};
        else                    e = {br != 2'd0, 32'd0};
        @(posedge CLK); #1;
        exp_q.push_back(e);
        launch(we, f3, a, wd);
        @(posedge CLK); #1;
        for (int i = 0; i < 80; i++) begin
            if (done_seen) break;
            // REQ and its fields are junk while the access is in flight
            REQ = $urandom_range(0, 1); REQ_WE = $urandom_range(0, 1);
            REQ_FUNCT3 = $urandom_range(0, 7); REQ_ADDR = $urandom; REQ_WDATA = $urandom;
            @(posedge CLK); #1;
        end
        REQ = 0;
        if (!done_seen) begin
            chk("done_timeout", 0, 1);
            apply_reset();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_mem_wait", MEM_WAIT, 0);
        @(posedge CLK); #2 RST = 1;

        // LW, zero-wait slave
        do_access(0, 3'd2, 32'h100, 0, 32'h1234_5678, 0, 0, 1, -1);
        chk("lw_araddr", cap_araddr, 32'h100);
        chk("lw_rdata", last_rdata, 32'h1234_5678);
        chk("lw_err", last_err, 0);
        // byte/half extraction
        do_access(0, 3'd0, 32'h103, 0, 32'h80AA_BBCC, 0, 0, 1, -1);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        do_access(0, 3'd4, 32'h103, 0, 32'h80AA_BBCC, 0, 0, 0, -1);
        chk("lbu_rdata", last_rdata, 32'h0000_0080);
        do_access(0, 3'd5, 32'h102, 0, 32'h80AA_BBCC, 0, 0, 0, -1);
        chk("lhu_rdata", last_rdata, 32'h0000_80AA);
        // SH with AWREADY held off three cycles
        do_access(1, 3'd1, 32'h202, 32'h0000_BEEF, 0, 0, 0, 0, 3);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh_wstrb", cap_strb, 4'b1100);
        chk("sh_awaddr", cap_awaddr, 32'h200);
        chk("sh_rdata", last_rdata, 0);
        chk("sh_err", last_err, 0);
        // error paths
        do_access(0, 3'd2, 32'h101, 0, 32'hDEAD_BEEF, 0, 0, 0, -1);
        chk("mis_err", last_err, 1);
        chk("mis_rdata", last_rdata, 0);
        do_access(1, 3'd3, 32'h100, 32'h5555_5555, 0, 0, 0, 0, -1);
        chk("ill_err", last_err, 1);
        do_access(0, 3'd2, 32'h400, 0, 32'hCAFE_0001, 2'b10, 0, 0, -1);
        chk("slverr_err", last_err, 1);
        do_access(0, 3'd2, 32'h404, 0, 32'hCAFE_0002, 0, 0, 0, -1);
        chk("err_cleared", last_err, 0);
        chk("err_clear_rdata", last_rdata, 32'hCAFE_0002);

        // reset while in RD_D with the read data held back
        set_cfg(0, -1);
        r_dly = 20; r_word = 32'h0BAD_0BAD; r_resp = 0;
        @(posedge CLK); #1;
        launch(0, 3'd2, 32'h300, 0);
        @(posedge CLK); #1;
        REQ = 0;
        for (int i = 0; i < 10; i++) begin
            if (M_AXI_RREADY) break;
            @(posedge CLK); #1;
        end
        chk("pre_rst_rready", M_AXI_RREADY, 1);
        #2 RST = 0;
        #1;
        chk("mid_rst_rready", M_AXI_RREADY, 0);
        chk("mid_rst_mem_wait", MEM_WAIT, 0);
        chk("mid_rst_done", DONE, 0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #2 RST = 1;
        do_access(0, 3'd1, 32'h502, 0, 32'h8001_7FFF, 0, 0, 1, -1);
        chk("post_rst_lh", last_rdata, 32'hFFFF_8001);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1)) a[1:0] = 2'b00;
            do_access($urandom_range(0, 1), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0,
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0,
                      $urandom_range(0, 4) == 0, -1);
        end

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
